usb_stream_arbiter: RTL and testbench
=====================================

USB_STREAM_ARBITER -- requirements
Module: usb_stream_arbiter

Interface
REQ-001 Parameter NUM_SOURCES, default 2, SHALL set the number of packet-stream requesters (2..4).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the byte-stream width.
REQ-003 Parameter COUNT_WIDTH, default 16, SHALL set the width of each per-source packet counter.
REQ-004 clk  input  1  SHALL be the single clock for all logic.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 s_tdata  input  NUM_SOURCES*DATA_WIDTH  SHALL carry source bytes; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_tvalid  input  NUM_SOURCES  SHALL be per-source valid.
REQ-008 s_tlast  input  NUM_SOURCES  SHALL mark the last byte of a source packet.
REQ-009 s_tready  output  NUM_SOURCES  SHALL be per-source ready.
REQ-010 m_tdata  output  DATA_WIDTH  SHALL be the merged byte stream to the USB FIFO.
REQ-011 m_tvalid / m_tlast  output  1 each  SHALL be merged valid / end-of-packet.
REQ-012 m_tready  input  1  SHALL be USB FIFO ready.
REQ-013 grant  output  NUM_SOURCES  SHALL be one-hot owner of the output, zero when idle.
REQ-014 pkt_count  output  NUM_SOURCES*COUNT_WIDTH  SHALL give per-source completed-packet counts.

Function
REQ-015 States SHALL be ARB_IDLE and ARB_FORWARD.
REQ-016 ARB_IDLE: if any s_tvalid is high, the arbiter SHALL select the first requester searching from (last_grant+1) mod NUM_SOURCES, register it in grant, and enter ARB_FORWARD next cycle; otherwise it SHALL remain in ARB_IDLE.
REQ-017 In ARB_IDLE all s_tready SHALL be 0.
REQ-018 ARB_FORWARD: s_tready[g] SHALL equal (!m_tvalid || m_tready) for granted g; all other s_tready SHALL be 0.
REQ-019 Output SHALL be a single register stage: a byte accepted in cycle k appears on m_tdata/m_tlast with m_tvalid high in cycle k+1.
REQ-020 m_tvalid SHALL hold, and m_tdata/m_tlast SHALL remain stable, while m_tready is 0.
REQ-021 m_tvalid SHALL clear after an output handshake unless a new byte is accepted in the same cycle.
REQ-022 Acceptance of a byte with s_tlast[g]=1 SHALL return the FSM to ARB_IDLE, clear grant, update last_grant to g, and increment pkt_count[g].
REQ-023 Arbitration SHALL be packet-atomic: grant never changes mid-packet, including while the granted source holds s_tvalid low.
REQ-024 Inter-packet overhead SHALL be exactly one idle cycle (ARB_IDLE) on the source side; the output register may still drain during that cycle.
REQ-025 With a single active requester, it SHALL be re-granted every packet.
REQ-026 pkt_count SHALL saturate at all-ones and not wrap.
REQ-027 Non-granted sources' tdata/tlast SHALL never reach m_tdata.

Reset
REQ-028 On rst_n low, asynchronously: state=ARB_IDLE, grant=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, pkt_count=0, last_grant=NUM_SOURCES-1, so source 0 wins first.
REQ-029 Reset mid-packet SHALL discard the partial packet in the output register; after release, arbitration restarts per REQ-028.

Structure
REQ-030 The FSM state typedef (arb_state_t) and a default COUNT_WIDTH constant SHALL live in a shared package usb_arbiter_package.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_priority_select, with inputs request vector and last_grant and a one-hot output.
REQ-032 The block SHALL sit between the COBS-encoded XADC packet stream (and future sources) and the 8-bit USB FIFO.

Verification
REQ-033 Source 0 sends a 3-byte packet {0x11,0x22,0x33}, m_tready=1 -> bytes appear on consecutive cycles, 1 cycle after acceptance, tlast on 0x33, pkt_count[0]=1.
REQ-034 Sources 0 and 1 both request continuously with 2-byte packets -> grants alternate 0,1,0,1; each packet is contiguous; 1 idle source-side cycle between packets.
REQ-035 m_tready=0 for 5 cycles mid-packet -> m_tdata is stable, s_tready[g]=0, no byte lost or duplicated.
REQ-036 Granted source drops s_tvalid for 10 cycles mid-packet while source 1 requests -> grant stays, and source 1 waits until the tlast handshake.
REQ-037 rst_n is pulsed low asynchronously mid-packet -> all outputs are 0 immediately; after release, source 0 is granted first.
REQ-038 pkt_count[1] is preloaded to near saturation via 0xFFFF+2 packets (or a forced value) -> count holds at 0xFFFF.

Source files
------------

// File: rtl/usb_arbiter_package.sv
// usb_arbiter_package: arbiter FSM state type and default packet-counter width
package usb_arbiter_package;
    typedef enum logic {ARB_IDLE, ARB_FORWARD} arb_state_t;
    localparam int DEFAULT_COUNT_WIDTH = 16;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: one-hot round-robin pick, searching upward from last_grant+1
module rr_priority_select #(
    parameter int N = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt
);
    int idx;
    logic [N-1:0] rot;
    // nearest offset is visited last so it overrides farther candidates
    always_comb begin
        gnt = '0;
        idx = 0;
        rot = '0;
        for (int o = N; o >= 1; o--) begin
            idx = (int'(last_grant) + o) % N;
            rot = req >> idx;
            if (rot[0]) gnt = N'(1) << idx;
        end
    end
endmodule

// File: rtl/usb_stream_arbiter.sv
// usb_stream_arbiter: packet-atomic round-robin merge of source byte streams into the
// USB FIFO through a single output register, with saturating per-source packet counts.
module usb_stream_arbiter
    import usb_arbiter_package::*;
#(
    parameter int NUM_SOURCES = 2,
    parameter int DATA_WIDTH = 8,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_SOURCES-1:0]             s_tvalid,
    input  logic [NUM_SOURCES-1:0]             s_tlast,
    output logic [NUM_SOURCES-1:0]             s_tready,
    output logic [DATA_WIDTH-1:0]              m_tdata,
    output logic                               m_tvalid,
    output logic                               m_tlast,
    input  logic                               m_tready,
    output logic [NUM_SOURCES-1:0]             grant,
    output logic [NUM_SOURCES*COUNT_WIDTH-1:0] pkt_count
);
    localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    arb_state_t state;
    logic [IW-1:0] last_grant, gidx;
    logic [NUM_SOURCES-1:0] pick, accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic sel_last, free, take, done;

    rr_priority_select #(.N(NUM_SOURCES), .IW(IW)) u_rr (
        .req(s_tvalid),
        .last_grant(last_grant),
        .gnt(pick)
    );

    assign free = !m_tvalid || m_tready;
    assign s_tready = (state == ARB_FORWARD) ? grant & {NUM_SOURCES{free}} : '0;
    assign accept = s_tvalid & s_tready;
    assign take = |accept;
    assign done = take && sel_last;

    // grant is one-hot, so an AND-OR mux keeps other sources off the output
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        gidx = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            sel_data = sel_data | (s_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
            sel_last = sel_last | (s_tlast[i] & grant[i]);
            if (grant[i]) gidx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            grant <= '0;
            last_grant <= IW'(NUM_SOURCES - 1);
        end else if (state == ARB_IDLE) begin
            if (|s_tvalid) begin
                grant <= pick;
                state <= ARB_FORWARD;
            end
        end else if (done) begin
            grant <= '0;
            last_grant <= gidx;
            state <= ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tlast <= 1'b0;
            m_tdata <= '0;
        end else if (take) begin
            m_tvalid <= 1'b1;
            m_tlast <= sel_last;
            m_tdata <= sel_data;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (done) begin
            for (int i = 0; i < NUM_SOURCES; i++)
                if (grant[i] && !(&pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH]))
                    pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] <= pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_usb_stream_arbiter.sv
// tb_usb_stream_arbiter: directed and random traffic checked against a transaction-level
// model (per-source packet queues, round-robin owner choice, one-deep output queue).
module tb_usb_stream_arbiter;
    localparam int NS = 3, DW = 8, CW = 8, SW = $clog2(NS);
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0] s_tvalid, s_tlast, s_tready, grant;
    logic [DW-1:0] m_tdata;
    logic m_tvalid, m_tlast, m_tready;
    logic [NS*CW-1:0] pkt_count;

    usb_stream_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [DW:0] src_q [NS][$];
    logic [DW:0] out_q [$];
    logic [DW:0] seen [$];
    int owners [$];
    int cnt [NS];
    logic [NS-1:0] exp_grant, en;
    int exp_last, vprob, rprob, maxlen;
    logic auto_fill;
    logic [DW:0] t1_exp [3];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(logic [NS-1:0] req, int last);
        for (int o = 1; o <= NS; o++) begin
            int k = (last + o) % NS;
            if (req[k[SW-1:0]]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NS*CW-1:0] packed_cnt();
        logic [NS*CW-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i*CW +: CW] = CW'(cnt[i]);
        return v;
    endfunction

    task automatic push_pkt(int i, int len);
        for (int k = 0; k < len; k++) src_q[i].push_back({k == len - 1, DW'($urandom)});
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (auto_fill && en[i] && src_q[i].size() == 0) push_pkt(i, int'($urandom_range(1, maxlen)));
            s_tvalid[i] = en[i] && src_q[i].size() != 0 && $urandom_range(99) < vprob;
            s_tdata[i*DW +: DW] = src_q[i].size() != 0 ? src_q[i][0][DW-1:0] : DW'($urandom);
            s_tlast[i] = src_q[i].size() != 0 ? src_q[i][0][DW] : 1'b0;
        end
        m_tready = $urandom_range(99) < rprob;
    endtask

    // called at posedge+1; checks at the following negedge, then advances the model
    task automatic cycle();
        logic [NS-1:0] rdy, acc, nxt;
        int p;
        drive();
        @(negedge clk);
        rdy = exp_grant & {NS{out_q.size() == 0 || m_tready}};
        check("grant", grant, exp_grant);
        check("s_tready", s_tready, rdy);
        check("m_tvalid", m_tvalid, out_q.size() != 0);
        if (out_q.size() != 0) check("m_data", {m_tlast, m_tdata}, out_q[0]);
        check("pkt_count", pkt_count, packed_cnt());
        if (m_tvalid && m_tready) seen.push_back({m_tlast, m_tdata});
        if (rst_n) begin
            acc = s_tvalid & rdy;
            nxt = exp_grant;
            if (out_q.size() != 0 && m_tready) void'(out_q.pop_front());
            if (exp_grant == '0 && s_tvalid != '0) begin
                p = rr_pick(s_tvalid, exp_last);
                nxt = NS'(1) << p;
                owners.push_back(p);
            end
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) begin
                    out_q.push_back(src_q[i][0]);
                    if (src_q[i][0][DW]) begin
                        cnt[i] = cnt[i] == CMAX ? CMAX : cnt[i] + 1;
                        exp_last = i;
                        nxt = '0;
                    end
                    void'(src_q[i].pop_front());
                end
            end
            exp_grant = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic model_reset();
        exp_grant = '0;
        exp_last = NS - 1;
        out_q.delete();
        for (int i = 0; i < NS; i++) begin
            cnt[i] = 0;
            src_q[i].delete();
        end
    endtask

    initial begin
        t1_exp[0] = 9'h011;
        t1_exp[1] = 9'h022;
        t1_exp[2] = 9'h133;
        model_reset();
        en = '0; vprob = 100; rprob = 100; maxlen = 4; auto_fill = 1'b0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run(2);
        rst_n = 1'b1;
        run(2);

        // single 3-byte packet from source 0
        seen.delete();
        src_q[0].push_back(9'h011);
        src_q[0].push_back(9'h022);
        src_q[0].push_back(9'h133);
        en = 3'b001;
        run(8);
        check("t1_len", seen.size(), 3);
        for (int k = 0; k < seen.size() && k < 3; k++) check("t1_byte", seen[k], t1_exp[k]);
        check("t1_count", pkt_count[CW-1:0], 1);

        // two sources with 2-byte packets; source 0 was last served, so source 1 leads
        owners.delete();
        push_pkt(0, 2); push_pkt(0, 2);
        push_pkt(1, 2); push_pkt(1, 2);
        en = 3'b011;
        run(16);
        check("alt_len", owners.size(), 4);
        for (int k = 0; k < owners.size() && k < 4; k++) check("alt_owner", owners[k], (k % 2 == 0) ? 1 : 0);

        // output stall mid-packet
        push_pkt(0, 4);
        en = 3'b001;
        run(3);
        rprob = 0;
        run(5);
        rprob = 100;
        run(6);

        // granted source pauses while another requests
        push_pkt(0, 4);
        en = 3'b001;
        run(2);
        push_pkt(1, 2);
        en = 3'b010;
        run(10);
        check("hold_grant", grant, 3'b001);
        en = 3'b011;
        run(15);

        // random traffic
        auto_fill = 1'b1; en = 3'b111; vprob = 70; rprob = 70;
        run(3000);

        // asynchronous reset mid-packet
        for (int k = 0; k < 100 && !(grant != '0 && m_tvalid); k++) cycle();
        check("midpkt_found", grant != '0 && m_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_tready", s_tready, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_mlast", m_tlast, 0);
        check("rst_mdata", m_tdata, 0);
        check("rst_count", pkt_count, 0);
        model_reset();
        en = '0;
        @(posedge clk);
        #1;
        run(2);
        owners.delete();
        rst_n = 1'b1;
        en = 3'b111; vprob = 100; rprob = 100;
        run(6);
        check("first_after_rst", owners.size() > 0 ? owners[0] : -1, 0);

        // drain, then saturate source 1's counter
        auto_fill = 1'b0;
        run(30);
        en = 3'b010;
        for (int k = 0; k < 260; k++) src_q[1].push_back({1'b1, DW'($urandom)});
        run(600);
        check("sat", pkt_count[CW +: CW], CMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
